// File: rtl/bus4_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus4_rr_arbiter_pkg
// Shared definitions for the nibble-bus round-robin arbiter:
//   state_t   : arbiter FSM states (IDLE, GRANT, TURN)
//   BUS4_W    : width of the arbitrated tri-state bus (one nibble)
//   clog2     : ceiling log2 for parameter-derived widths
//   id_width  : owner-index width, never narrower than 1 bit
// Optional feature macro used by the top: BUS4_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package bus4_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int unsigned BUS4_W = 4;

  typedef logic [BUS4_W-1:0] nibble_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus4_rr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// bus4_rr_pick
// Combinational rotate-priority picker. Scans elig_i starting at ptr_i,
// then ptr_i+1 .. N-1, 0 .. ptr_i-1, and reports the first set index.
// Ports:
//   elig_i  in  N    eligible request mask
//   ptr_i   in  IDW  scan start index (always < N)
//   hit_o   out 1    at least one eligible request
//   idx_o   out IDW  first eligible index in rotated order (0 when no hit)
// -----------------------------------------------------------------------------
module bus4_rr_pick
  import bus4_rr_arbiter_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   elig_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           hit_o,
  output logic [IDW-1:0] idx_o
);

  int unsigned j;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr_i) + i) % N;
      if (!hit_o && elig_i[j]) begin
        hit_o = 1'b1;
        idx_o = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/bus4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus4_rr_arbiter
// Round-robin arbiter driving the active-low output enables of N 74x244-style
// nibble buffers. At most one enable is low; every change of owner passes
// through a single all-off TURN cycle so two buffers never drive together.
// All outputs are registered (no req -> g_n combinational path).
// Ports:
//   clk      in   1    rising-edge clock
//   rst      in   1    asynchronous active-high reset
//   req      in   N    per-source request, held for the whole transfer
//   g_n      out  N    active-low one-hot bus enables (all 1 = bus floating)
//   gnt      out  N    active-high copy of the grant
//   gnt_id   out  IDW  current owner index, meaningful while busy=1
//   busy     out  1    high while in GRANT
//   timeout  out  1    one-cycle pulse in the TURN after a forced revoke
// Optional feature: define BUS4_ARB_TIMEOUT_EN to bound each ownership to
// TIMEOUT GRANT cycles; a revoked source stays blocked until its req drops.
// Without the macro ownership is unbounded and timeout is tied low.
// -----------------------------------------------------------------------------
module bus4_rr_arbiter
  import bus4_rr_arbiter_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  output logic [N-1:0]           g_n,
  output logic [N-1:0]           gnt,
  output logic [id_width(N)-1:0] gnt_id,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned IDW = id_width(N);

  if (N < 1 || N > 16) begin : g_bad_n
    $error("bus4_rr_arbiter: N must be 1..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("bus4_rr_arbiter: TIMEOUT must be >= 2");
  end

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [N-1:0]   g_n_q,   g_n_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic           busy_q,  busy_d;

  logic [N-1:0]   elig;
  logic           pick_hit;
  logic [IDW-1:0] pick_idx;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] id);
    if (32'(id) == N - 1) return '0;
    return id + 1'b1;
  endfunction

`ifdef BUS4_ARB_TIMEOUT_EN
  localparam int unsigned CW = clog2(TIMEOUT);

  logic [CW-1:0] cnt_q,     cnt_d;
  logic [N-1:0]  blocked_q, blocked_d;
  logic          timeout_q, timeout_d;

  assign elig    = req & ~blocked_q;
  assign timeout = timeout_q;
`else
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  bus4_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .hit_o  (pick_hit),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef BUS4_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    blocked_d = blocked_q & req;  // any cycle with req low releases the block
`endif

    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        if (pick_hit) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          ptr_d   = ptr_after(pick_idx);
`ifdef BUS4_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          state_d = ST_TURN;
`ifdef BUS4_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive GRANT cycle: revoke and block the owner
          state_d            = ST_TURN;
          timeout_d          = 1'b1;
          blocked_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    g_n_d = '1;
    if (state_d == ST_GRANT) g_n_d[owner_d] = 1'b0;
    gnt_d  = ~g_n_d;
    busy_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      g_n_q   <= '1;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      g_n_q   <= g_n_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS4_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign g_n    = g_n_q;
  assign gnt    = gnt_q;
  assign gnt_id = owner_q;
  assign busy   = busy_q;

endmodule
